// File: rtl/pop_ctrl_alloc.sv
// Registered per-output pop control: grant qualification, conflict resolution and credit tracking.
// Optional wormhole locking per output is enabled by defining POP_CTRL_PKT_LOCK_EN.
module pop_ctrl_alloc #(
    parameter int unsigned PORTS   = 7,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         vc_valid,
    input  logic [PORTS*IDX_W-1:0]   sa_grant,
    input  logic [PORTS-1:0]         credit_ret,
`ifdef POP_CTRL_PKT_LOCK_EN
    input  logic [PORTS-1:0]         tail,
`endif
    output logic [PORTS-1:0]         pop_ctrl,
    output logic [PORTS*IDX_W-1:0]   xbar_sel,
    output logic [PORTS-1:0]         pop_in,
    output logic [PORTS*CNT_W-1:0]   credit_cnt,
    output logic                     conflict_err,
    output logic                     credit_err
);

    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(PORTS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

    logic [PORTS-1:0]         pop_q;
    logic [PORTS*IDX_W-1:0]   xbar_q;
    logic [PORTS*IDX_W-1:0]   xbar_d;
    logic [PORTS-1:0]         pin_q;
    logic                     conflict_q;
    logic                     credit_err_q;
    logic [CNT_W-1:0]         cnt_q [PORTS];
    logic [CNT_W-1:0]         cnt_d [PORTS];

    logic [IDX_W-1:0]         eff [PORTS];
    logic [PORTS-1:0]         cand;
    logic [PORTS-1:0]         fire;
    logic [PORTS-1:0]         claimed;
    logic                     conflict_now;
    logic                     overflow_now;

`ifdef POP_CTRL_PKT_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]               state_q [PORTS];
    logic [0:0]               state_d [PORTS];
    logic [IDX_W-1:0]         src_q   [PORTS];
    logic [IDX_W-1:0]         src_d   [PORTS];
    logic [PORTS-1:0]         reserved;
`endif

    // Effective source per output; out-of-range grants collapse to "none".
    always_comb begin
        for (int k = 0; k < PORTS; k++) begin
            eff[k] = sa_grant[k*IDX_W +: IDX_W];
            if (eff[k] > MAX_IDX) begin
                eff[k] = '0;
            end
`ifdef POP_CTRL_PKT_LOCK_EN
            if (state_q[k] == ST_LOCKED) begin
                eff[k] = src_q[k];
            end
`endif
        end
    end

    // Lowest-index output wins a shared input; locked sources are reserved first.
    always_comb begin
        cand         = '0;
        fire         = '0;
        claimed      = '0;
        conflict_now = 1'b0;
`ifdef POP_CTRL_PKT_LOCK_EN
        reserved = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (state_q[k] == ST_LOCKED && src_q[k] != '0) begin
                reserved[src_q[k] - 1'b1] = 1'b1;
            end
        end
`endif
        for (int k = 0; k < PORTS; k++) begin
            if (eff[k] != '0) begin
                cand[k] = vc_valid[eff[k] - 1'b1] && (cnt_q[k] != '0);
            end
            if (cand[k]) begin
`ifdef POP_CTRL_PKT_LOCK_EN
                if (reserved[eff[k] - 1'b1] && state_q[k] != ST_LOCKED) begin
                    conflict_now = 1'b1;
                end else
`endif
                if (claimed[eff[k] - 1'b1]) begin
                    conflict_now = 1'b1;
                end else begin
                    fire[k]                  = 1'b1;
                    claimed[eff[k] - 1'b1]   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        xbar_d = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (fire[k]) begin
                xbar_d[k*IDX_W +: IDX_W] = eff[k];
            end
        end
    end

    // A return into a full counter is dropped and flagged.
    always_comb begin
        overflow_now = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (fire[k] && !credit_ret[k]) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end else if (credit_ret[k] && !fire[k]) begin
                if (cnt_q[k] == CNT_FULL) begin
                    overflow_now = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

`ifdef POP_CTRL_PKT_LOCK_EN
    always_comb begin
        for (int k = 0; k < PORTS; k++) begin
            state_d[k] = state_q[k];
            src_d[k]   = src_q[k];
            if (fire[k]) begin
                if (state_q[k] == ST_IDLE) begin
                    if (!tail[eff[k] - 1'b1]) begin
                        state_d[k] = ST_LOCKED;
                        src_d[k]   = eff[k];
                    end
                end else if (tail[src_q[k] - 1'b1]) begin
                    state_d[k] = ST_IDLE;
                    src_d[k]   = '0;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_q        <= '0;
            xbar_q       <= '0;
            pin_q        <= '0;
            conflict_q   <= 1'b0;
            credit_err_q <= 1'b0;
            for (int k = 0; k < PORTS; k++) begin
                cnt_q[k] <= CNT_FULL;
`ifdef POP_CTRL_PKT_LOCK_EN
                state_q[k] <= ST_IDLE;
                src_q[k]   <= '0;
`endif
            end
        end else begin
            pop_q        <= fire;
            xbar_q       <= xbar_d;
            pin_q        <= claimed;
            conflict_q   <= conflict_q | conflict_now;
            credit_err_q <= credit_err_q | overflow_now;
            for (int k = 0; k < PORTS; k++) begin
                cnt_q[k] <= cnt_d[k];
`ifdef POP_CTRL_PKT_LOCK_EN
                state_q[k] <= state_d[k];
                src_q[k]   <= src_d[k];
`endif
            end
        end
    end

    always_comb begin
        credit_cnt = '0;
        for (int k = 0; k < PORTS; k++) begin
            credit_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign pop_ctrl     = pop_q;
    assign xbar_sel     = xbar_q;
    assign pop_in       = pin_q;
    assign conflict_err = conflict_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_pop_ctrl_alloc.sv
// Table-driven bench for pop_ctrl_alloc; lock sequences run when POP_CTRL_PKT_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_pop_ctrl_alloc;
    localparam int P  = 7;
    localparam int IW = 3;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [P-1:0]      vc_valid = '0;
    logic [P*IW-1:0]   sa_grant = '0;
    logic [P-1:0]      credit_ret = '0;
    logic [P-1:0]      tl = '0;
    logic [P-1:0]      pop_ctrl;
    logic [P*IW-1:0]   xbar_sel;
    logic [P-1:0]      pop_in;
    logic [P*CW-1:0]   credit_cnt;
    logic              conflict_err;
    logic              credit_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pop_ctrl_alloc #(.PORTS(P), .IDX_W(IW), .CREDITS(4), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vc_valid     (vc_valid),
        .sa_grant     (sa_grant),
        .credit_ret   (credit_ret),
`ifdef POP_CTRL_PKT_LOCK_EN
        .tail         (tl),
`endif
        .pop_ctrl     (pop_ctrl),
        .xbar_sel     (xbar_sel),
        .pop_in       (pop_in),
        .credit_cnt   (credit_cnt),
        .conflict_err (conflict_err),
        .credit_err   (credit_err)
    );

    typedef struct {
        logic [P-1:0]    vc;
        logic [P*IW-1:0] sa;
        logic [P-1:0]    ret;
        logic [P-1:0]    tl;
        logic [P-1:0]    e_pop;
        logic [P*IW-1:0] e_xbar;
        logic [P-1:0]    e_pin;
        logic [P*CW-1:0] e_cnt;
        logic            e_cerr;
        logic            e_crerr;
    } vec_t;

    vec_t tbl[$];
    vec_t ltbl[$];

    function automatic logic [P*IW-1:0] g(input int o, input int v);
        logic [P*IW-1:0] r;
        r = '0;
        r[o*IW +: IW] = IW'(v);
        return r;
    endfunction

    function automatic logic [P*CW-1:0] cp(input int c0, input int c1, input int c2, input int c3,
                                           input int c4, input int c5, input int c6);
        logic [P*CW-1:0] r;
        r = '0;
        r[0*CW +: CW] = CW'(c0);
        r[1*CW +: CW] = CW'(c1);
        r[2*CW +: CW] = CW'(c2);
        r[3*CW +: CW] = CW'(c3);
        r[4*CW +: CW] = CW'(c4);
        r[5*CW +: CW] = CW'(c5);
        r[6*CW +: CW] = CW'(c6);
        return r;
    endfunction

    function automatic vec_t mk(input logic [P-1:0] vc, input logic [P*IW-1:0] sa,
                                input logic [P-1:0] ret, input logic [P-1:0] t,
                                input logic [P-1:0] pop, input logic [P*IW-1:0] xb,
                                input logic [P-1:0] pin, input logic [P*CW-1:0] cnt,
                                input logic ce, input logic cre);
        vec_t v;
        v.vc = vc; v.sa = sa; v.ret = ret; v.tl = t;
        v.e_pop = pop; v.e_xbar = xb; v.e_pin = pin; v.e_cnt = cnt;
        v.e_cerr = ce; v.e_crerr = cre;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [P-1:0] pop, input logic [P*IW-1:0] xb,
                           input logic [P-1:0] pin, input logic [P*CW-1:0] cnt,
                           input logic ce, input logic cre);
        chk({tag, " pop_ctrl"}, 64'(pop_ctrl), 64'(pop));
        chk({tag, " xbar_sel"}, 64'(xbar_sel), 64'(xb));
        chk({tag, " pop_in"}, 64'(pop_in), 64'(pin));
        chk({tag, " credit_cnt"}, 64'(credit_cnt), 64'(cnt));
        chk({tag, " conflict_err"}, 64'(conflict_err), 64'(ce));
        chk({tag, " credit_err"}, 64'(credit_err), 64'(cre));
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        vc_valid = v.vc; sa_grant = v.sa; credit_ret = v.ret; tl = v.tl;
        @(posedge clk);
        #1;
        chk_all(tag, v.e_pop, v.e_xbar, v.e_pin, v.e_cnt, v.e_cerr, v.e_crerr);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        vc_valid = '0; sa_grant = '0; credit_ret = '0; tl = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_all(tag, '0, '0, '0, cp(4, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [P-1:0] z;
        z = '0;
        // Single grant, credit exhaustion and a returned credit.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(7'h04, g(0, 3), z, z, 7'h01, g(0, 3), 7'h04,
                             cp(3 - i, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0));
        tbl.push_back(mk(7'h04, g(0, 3), z, z, z, '0, z, cp(0, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0));
        tbl.push_back(mk(7'h04, g(0, 3), 7'h01, z, z, '0, z, cp(1, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0));
        tbl.push_back(mk(7'h04, g(0, 3), z, z, 7'h01, g(0, 3), 7'h04,
                         cp(0, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(z, '0, 7'h01, z, z, '0, z, cp(i, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0));
        // Outputs 1 and 4 both claim input 0.
        tbl.push_back(mk(7'h01, g(1, 1) | g(4, 1), z, z, 7'h02, g(1, 1), 7'h01,
                         cp(4, 3, 4, 4, 4, 4, 4), 1'b1, 1'b0));
        tbl.push_back(mk(z, '0, z, z, z, '0, z, cp(4, 3, 4, 4, 4, 4, 4), 1'b1, 1'b0));
        // Return into a full counter on output 3; normal return on output 1.
        tbl.push_back(mk(z, '0, 7'h0a, z, z, '0, z, cp(4, 4, 4, 4, 4, 4, 4), 1'b1, 1'b1));
        // Fire and return in the same cycle.
        tbl.push_back(mk(7'h40, g(5, 7), 7'h20, z, 7'h20, g(5, 7), 7'h40,
                         cp(4, 4, 4, 4, 4, 4, 4), 1'b1, 1'b1));
        // Parallel grants, one with an empty input.
        tbl.push_back(mk(7'h03, g(0, 1) | g(1, 2) | g(2, 3), z, z, 7'h03, g(0, 1) | g(1, 2), 7'h03,
                         cp(3, 3, 4, 4, 4, 4, 4), 1'b1, 1'b1));
        // Three-way claim on input 4.
        tbl.push_back(mk(7'h10, g(6, 5) | g(3, 5) | g(2, 5), z, z, 7'h04, g(2, 5), 7'h10,
                         cp(3, 3, 3, 4, 4, 4, 4), 1'b1, 1'b1));

        ltbl.push_back(mk(7'h20, g(2, 6), z, z, 7'h04, g(2, 6), 7'h20,
                          cp(4, 4, 3, 4, 4, 4, 4), 1'b0, 1'b0));
        ltbl.push_back(mk(7'h21, g(2, 1), z, z, 7'h04, g(2, 6), 7'h20,
                          cp(4, 4, 2, 4, 4, 4, 4), 1'b0, 1'b0));
        ltbl.push_back(mk(7'h20, g(0, 6) | g(2, 1), z, z, 7'h04, g(2, 6), 7'h20,
                          cp(4, 4, 1, 4, 4, 4, 4), 1'b1, 1'b0));
        ltbl.push_back(mk(7'h20, g(2, 1), 7'h04, 7'h20, 7'h04, g(2, 6), 7'h20,
                          cp(4, 4, 1, 4, 4, 4, 4), 1'b1, 1'b0));
        ltbl.push_back(mk(7'h01, g(2, 1), 7'h04, z, 7'h04, g(2, 1), 7'h01,
                          cp(4, 4, 1, 4, 4, 4, 4), 1'b1, 1'b0));
        ltbl.push_back(mk(z, g(2, 3), z, z, z, '0, z, cp(4, 4, 1, 4, 4, 4, 4), 1'b1, 1'b0));

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", '0, '0, '0, cp(4, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Reset in mid-operation clears everything without a clock edge.
        async_reset("midrst");
        apply("post_rst", mk(7'h01, g(0, 1), z, z, 7'h01, g(0, 1), 7'h01,
                             cp(3, 4, 4, 4, 4, 4, 4), 1'b0, 1'b0));

`ifdef POP_CTRL_PKT_LOCK_EN
        async_reset("lock_pre");
        for (int i = 0; i < ltbl.size(); i++)
            apply($sformatf("lock%0d", i), ltbl[i]);
        async_reset("lock_rst");
        apply("lock_idle", mk(7'h04, g(2, 3), z, 7'h04, 7'h04, g(2, 3), 7'h04,
                              cp(4, 4, 3, 4, 4, 4, 4), 1'b0, 1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pop_ctrl_alloc.md
# pop_ctrl_alloc

Parametrised, registered successor to the router's per-output pop-control mux. It takes the switch allocator's per-output grant indices, input VC-valid flags and downstream credit returns. Each cycle it decides which granted transfers may fire and registers the results: per-output pop strobes, crossbar selects and per-input FIFO pop strobes. It sits between the switch allocator and the input buffers/crossbar. It owns the downstream credit counters and flags allocation conflicts.

## Interface
- PORTS, 7, number of input ports and output ports (square router, 2..15)
- IDX_W, 3, grant index width; must satisfy 2^IDX_W > PORTS
- CREDITS, 4, downstream buffer depth per output (1..2^CNT_W-1)
- CNT_W, 3, credit counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- vc_valid  in  PORTS  bit i: input i buffer non-empty
- sa_grant  in  PORTS*IDX_W  slice k (bits k*IDX_W+:IDX_W): input selected for output k; 0 = none, i+1 = input i
- credit_ret  in  PORTS  bit k: one credit returned by the downstream of output k
- tail  in  PORTS  bit i: head-of-buffer flit at input i is a tail (present only with POP_CTRL_PKT_LOCK_EN)
- pop_ctrl  out  PORTS  bit k: output k transfers a flit this cycle (registered)
- xbar_sel  out  PORTS*IDX_W  slice k: crossbar source for output k, 0 when idle (registered)
- pop_in  out  PORTS  bit i: pop input buffer i (registered)
- credit_cnt  out  PORTS*CNT_W  slice k: current credits for output k
- conflict_err  out  1  sticky: two outputs claimed one input in the same cycle
- credit_err  out  1  sticky: credit returned while the counter was at CREDITS

## Operation
- Effective index e[k] = sa_grant slice k. Values above PORTS count as 0, with no error.
- Candidate: e[k]!=0 && vc_valid[e[k]-1] && credit_cnt[k]!=0.
- Conflict resolution: when several candidates share an input, the lowest-index output wins and the others are suppressed. conflict_err sets and holds until reset.
- fire[k] = candidate and not suppressed.
- Registered outputs: pop_ctrl[k]<=fire[k]; xbar_sel[k]<=fire[k]?e[k]:0; pop_in[i]<=OR over k of (fire[k] && e[k]==i+1). At most one bit per input is ever set.
- Credits: cnt[k] <= cnt[k] - fire[k] + credit_ret[k].
  - Fire and return in the same cycle leave the count unchanged.
  - A return with cnt==CREDITS and no fire is dropped, and credit_err sets.
  - A fire with cnt==0 cannot occur, because the candidate condition excludes it.
- Reset values: pop_ctrl=0, xbar_sel=0, pop_in=0, every credit_cnt=CREDITS, conflict_err=0, credit_err=0, every lock state IDLE.

## Timing
- Latency is 1 cycle: a grant in cycle n appears on pop_ctrl/xbar_sel/pop_in in cycle n+1.
- Credit decrement happens on the same edge that registers the pop. A later grant in cycle n+1 sees the reduced count.
- Back-to-back: an output may fire every cycle while valid and credit hold. Throughput is 1 flit/cycle/output.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first possible pop is the cycle after the first clock edge with rst_n high.
- credit_cnt is registered state, driven directly.

## Configuration
- POP_CTRL_PKT_LOCK_EN defined: wormhole locking is enabled, and the `tail` port exists. Each output has a state machine with states IDLE and LOCKED(src).
  - IDLE: e[k] comes from sa_grant. A fire with tail[e-1]==0 moves the output to LOCKED(e).
  - LOCKED(src): sa_grant slice k is ignored and e[k]=src. A fire with tail[src-1]==1 returns the output to IDLE.
  - A locked source input is reserved for its locked output. Any other output selecting that input is suppressed, and conflict_err sets.
  - Locks survive lack of credit or valid; the output stalls in LOCKED.
- POP_CTRL_PKT_LOCK_EN undefined: there is no `tail` port and no lock state. Every cycle is decided independently from sa_grant.

## Test plan
- Reset, CREDITS=4: outputs are all 0 and every credit_cnt=4. Grant out0<-in2 (sa slice0=3) with vc_valid[2]=1 -> next cycle pop_ctrl[0]=1, xbar_sel slice0=3, pop_in[2]=1, cnt0=3.
- Hold grant for 5 cycles with no credit_ret -> exactly 4 pops, then pop_ctrl[0]=0 and cnt0=0. Pulse credit_ret[0] -> one further pop.
- Outputs 1 and 4 both grant input 0 -> only pop_ctrl[1]=1, pop_in[0]=1, conflict_err=1 and it stays set.
- credit_ret[3] with cnt3=4 and no fire -> cnt3 stays 4 and credit_err=1. Fire plus credit_ret in the same cycle -> count unchanged.
- Lock enabled: out2 fires from in5 with tail=0 -> LOCKED. sa slice2 then changes to 1, yet xbar_sel slice2 stays 6. out0 granting in5 is suppressed. A tail=1 pop releases the lock, and out2 follows sa_grant on the next grant.
- rst_n pulled low while LOCKED with cnt=1 -> outputs 0 immediately and cnt=CREDITS. After release, the state is IDLE.
